// File: rtl/sub_serial.sv
// Bit-serial WIDTH-bit subtractor (d = a - b - bi), LSB first, start/busy/done handshake.
// Define SUB_OVF_EN to add the signed-overflow output ovf.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH-1:0] d,
    output logic             bo,
    output logic             busy,
    output logic             done
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             brw_q, brw_d;
    logic             bo_q, bo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             diff_bit;
    logic             brw_nx;

`ifdef SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        acc_d    = acc_q;
        d_d      = d_q;
        brw_d    = brw_q;
        bo_d     = bo_q;
        cnt_d    = cnt_q;
`ifdef SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        diff_bit = a_sh_q[0] ^ b_sh_q[0] ^ brw_q;
        brw_nx   = (~a_sh_q[0] & b_sh_q[0])
                 | (~(a_sh_q[0] ^ b_sh_q[0]) & brw_q);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bi;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = SHIFT;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                // Result enters from the MSB end so bit 0 lands last at d[0].
                acc_d  = {diff_bit, acc_q[WIDTH-1:1]};
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                brw_d  = brw_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    d_d     = {diff_bit, acc_q[WIDTH-1:1]};
                    bo_d    = brw_nx;
`ifdef SUB_OVF_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (diff_bit != a_msb_q);
`endif
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            bo_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SUB_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            bo_q    <= bo_d;
            cnt_q   <= cnt_d;
`ifdef SUB_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign d    = d_q;
    assign bo   = bo_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
`ifdef SUB_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_sub_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bi;
    logic [W-1:0] d;
    logic         bo;
    logic         busy;
    logic         done;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .d     (d),
        .bo    (bo),
        .busy  (busy),
        .done  (done)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned subtraction in WIDTH+1 bits gives {bo, d}.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
        int unsigned r;
        r = (int'(x) - int'(y) - int'(c)) & ((1 << (W + 1)) - 1);
        return r[W:0];
    endfunction

    // Called just after an edge; accepting edge is the next one.
    // poke>0 pulses start with junk operands during SHIFT cycle poke.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbi, input int poke);
        logic [W:0]   exp;
        logic [W-1:0] prev_d;
        logic         prev_bo;
        exp     = ref_sub(ta, tb_, tbi);
        a       = ta;
        b       = tb_;
        bi      = tbi;
        start   = 1'b1;
        prev_d  = d;
        prev_bo = bo;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bi    = 1'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("done_after_accept", 32'(done), 32'd0);
        chk("d_held_shift", 32'(d), 32'(prev_d));
        for (int k = 1; k <= W; k++) begin
            if (k == poke) begin
                start = 1'b1;
                a     = 4'd1;
                b     = 4'd1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (k < W) begin
                chk("busy_shift", 32'(busy), 32'd1);
                chk("done_shift", 32'(done), 32'd0);
                chk("bo_held_shift", 32'(bo), 32'(prev_bo));
            end else begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
                chk("d_result", 32'(d), 32'(exp[W-1:0]));
                chk("bo_result", 32'(bo), 32'(exp[W]));
`ifdef SUB_OVF_EN
                chk("ovf_result", 32'(ovf),
                    32'((ta[W-1] != tb_[W-1]) && (exp[W-1] != ta[W-1])));
`endif
            end
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        chk("done_single_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bi    = 1'b0;
        #22;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("rst_d", 32'(d), 32'd0);
            chk("rst_bo", 32'(bo), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
        end

        run_op(4'd9, 4'd4, 1'b0, 0);
        chk("dir_9_4", 32'(d), 32'd5);
        idle_cycle();

        run_op(4'd3, 4'd7, 1'b1, 0);
        chk("dir_3_7_d", 32'(d), 32'd11);
        chk("dir_3_7_bo", 32'(bo), 32'd1);
        run_op(4'd0, 4'd0, 1'b1, 0);
        chk("b2b_d", 32'(d), 32'd15);
        chk("b2b_bo", 32'(bo), 32'd1);
        idle_cycle();

        run_op(4'd9, 4'd4, 1'b0, 2);
        chk("ignore_start_d", 32'(d), 32'd5);
        chk("ignore_start_bo", 32'(bo), 32'd0);
        idle_cycle();

        // Reset while shifting: outputs clear at once and no done follows.
        a     = 4'd12;
        b     = 4'd3;
        bi    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("async_rst_d", 32'(d), 32'd0);
        chk("async_rst_bo", 32'(bo), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", 32'(done), 32'd0);
            chk("no_busy_after_rst", 32'(busy), 32'd0);
        end
        run_op(4'd6, 4'd6, 1'b0, 0);
        chk("after_rst_d", 32'(d), 32'd0);
        chk("after_rst_bo", 32'(bo), 32'd0);
        idle_cycle();

`ifdef SUB_OVF_EN
        run_op(4'd8, 4'd1, 1'b0, 0);
        chk("ovf_8_1_d", 32'(d), 32'd7);
        chk("ovf_8_1", 32'(ovf), 32'd1);
        idle_cycle();
        run_op(4'd7, 4'd15, 1'b0, 0);
        chk("ovf_7_15_d", 32'(d), 32'd8);
        chk("ovf_7_15", 32'(ovf), 32'd1);
        idle_cycle();
        run_op(4'd5, 4'd2, 1'b0, 0);
        chk("ovf_5_2_d", 32'(d), 32'd3);
        chk("ovf_5_2", 32'(ovf), 32'd0);
        idle_cycle();
`endif

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1, 0) == 0) idle_cycle();
            run_op(W'($urandom), W'($urandom), 1'($urandom),
                   ($urandom_range(3, 0) == 0) ? int'($urandom_range(W - 1, 1)) : 0);
        end
        idle_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
